// File: rtl/pipemem_access.sv
// EXE/MEM pipeline register plus memory-access stage with a req/ack data bus and wait-state stall.
// Optional misaligned-access trap enabled by defining MEMACC_ALIGN_CHECK_EN.
module pipemem_access #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_stall,
    output logic [31:0] malu,
    output logic [31:0] mmo,
    output logic [4:0]  mrn,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mem_err
);

    // state   | meaning
    // ST_IDLE | M holds no outstanding memory operation
    // ST_WAIT | request on the bus, waiting for mem_ack or timeout
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [CNT_W-1:0] WLAST = CNT_W'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [31:0]        mb;
    logic               mwreg_r;
    logic               mwmem;
    logic               malign;
    logic [CNT_W-1:0]   wcnt;
    logic [31:0]        mmo_r;
    logic               pending;
    logic               tmo;
    logic               e_memop;
    logic               e_misalign;
    logic               e_issue;

    assign e_memop = ewmem | em2reg;

`ifdef MEMACC_ALIGN_CHECK_EN
    assign e_misalign = e_memop & (ealu[1:0] != 2'b00);
`else
    assign e_misalign = 1'b0;
`endif

    assign e_issue = e_memop & ~e_misalign;
    assign pending = (state == ST_WAIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmo       = 1'b0;
        mem_stall = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = e_issue ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_nxt = e_issue ? ST_WAIT : ST_IDLE;
                end else if (wcnt == WLAST) begin
                    // give up: release the pipeline and drop the access
                    tmo       = 1'b1;
                    state_nxt = e_issue ? ST_WAIT : ST_IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            malu    <= '0;
            mb      <= '0;
            mrn     <= '0;
            mwreg_r <= 1'b0;
            mm2reg  <= 1'b0;
            mwmem   <= 1'b0;
            malign  <= 1'b0;
            wcnt    <= '0;
            mmo_r   <= '0;
            mem_err <= 1'b0;
        end else begin
            if (!mem_stall) begin
                malu    <= ealu;
                mb      <= eb;
                mrn     <= ern;
                mwreg_r <= ewreg;
                mm2reg  <= em2reg;
                mwmem   <= ewmem;
                malign  <= e_misalign;
                wcnt    <= '0;
            end else begin
                wcnt    <= wcnt + 1'b1;
            end
            if (pending && mem_ack) begin
                mmo_r <= mem_rdata;
            end
            if (tmo || malign) begin
                mem_err <= 1'b1;
            end
        end
    end

    assign mem_req   = pending;
    assign mem_we    = pending & mwmem;
    assign mem_addr  = malu;
    assign mem_wdata = mb;

    // load data bypasses the holding register on the ack cycle so WB captures it on that edge
    assign mmo   = (pending && mem_ack) ? mem_rdata : mmo_r;
    assign mwreg = mwreg_r & ~mem_stall & ~tmo & ~malign;

endmodule

// File: tb/tb_pipemem_access.sv
// Scoreboard bench for pipemem_access: directed instructions, a latency-programmable memory
// responder, and a monitor that checks bus completions and WB write-backs against queued expectations.
module tb_pipemem_access;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ealu, eb;
    logic [4:0]  ern;
    logic        ewreg, em2reg, ewmem;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        mem_stall;
    logic [31:0] malu, mmo;
    logic [4:0]  mrn;
    logic        mwreg, mm2reg, mem_err;

    pipemem_access #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .ealu      (ealu),
        .eb        (eb),
        .ern       (ern),
        .ewreg     (ewreg),
        .em2reg    (em2reg),
        .ewmem     (ewmem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_stall (mem_stall),
        .malu      (malu),
        .mmo       (mmo),
        .mrn       (mrn),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mem_err   (mem_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic [4:0]  rn;
        logic [31:0] alu;
        logic        m2reg;
        logic [31:0] mo;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    bus_t bus_e;
    wb_t  wb_e;

    int compared   = 0;
    int mismatched = 0;

    int          lat       = 0;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_rd  = 32'h0;
    logic        stray     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // memory model: acks after 'lat' wait cycles, never when lat < 0
    initial begin : responder
        int cnt;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            if (reset || !mem_req) begin
                cnt       = 0;
                mem_ack   = stray & ~reset;
                mem_rdata = stray ? 32'h00000BAD : 32'h0;
            end else if (lat >= 0 && cnt == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = use_fixed ? fixed_rd : (mem_addr ^ 32'hA5A50000);
                cnt       = 0;
            end else begin
                mem_ack   = 1'b0;
                cnt++;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (mem_req && mem_ack) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_bus_completion", mem_addr, 32'hFFFFFFFF);
                end else begin
                    bus_e = bus_q.pop_front();
                    check("bus_we", {31'd0, mem_we}, {31'd0, bus_e.we});
                    check("bus_addr", mem_addr, bus_e.addr);
                    if (bus_e.we) check("bus_wdata", mem_wdata, bus_e.wdata);
                end
            end
            if (mwreg) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_wb_write", {27'd0, mrn}, 32'hFFFFFFFF);
                end else begin
                    wb_e = wb_q.pop_front();
                    check("wb_rn", {27'd0, mrn}, {27'd0, wb_e.rn});
                    check("wb_alu", malu, wb_e.alu);
                    check("wb_m2reg", {31'd0, mm2reg}, {31'd0, wb_e.m2reg});
                    if (wb_e.m2reg) check("wb_mmo", mmo, wb_e.mo);
                end
            end
            if (mem_stall) check("mwreg_during_stall", {31'd0, mwreg}, 32'd0);
        end
    end

    task automatic drive(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                         input logic wreg, input logic m2r, input logic wmem);
        ealu   = alu;
        eb     = b;
        ern    = rn;
        ewreg  = wreg;
        em2reg = m2r;
        ewmem  = wmem;
    endtask

    // present an instruction until the stage advances; returns stall cycles seen meanwhile
    task automatic step(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                        input logic wreg, input logic m2r, input logic wmem, output int stalls);
        drive(alu, b, rn, wreg, m2r, wmem);
        stalls = 0;
        forever begin
            @(negedge clock);
            if (!mem_stall) break;
            stalls++;
            if (stalls > 100) begin
                check("stall_bound_expired", 32'(stalls), 32'd0);
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic nop(output int stalls);
        step(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, stalls);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        // reset in the middle of a withheld load
        lat = -1;
        step(32'h100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, n);
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #3;
        check("pre_reset_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_req_drop", {31'd0, mem_req}, 32'd0);
        check("reset_stall_drop", {31'd0, mem_stall}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("rst_mwreg", {31'd0, mwreg}, 32'd0);
        check("rst_malu", malu, 32'd0);
        check("rst_mmo", mmo, 32'd0);
        check("rst_mrn", {27'd0, mrn}, 32'd0);
        check("rst_mem_err", {31'd0, mem_err}, 32'd0);
        @(posedge clock);
        #1;

        // ALU op
        wb_q.push_back('{rn: 5'd5, alu: 32'h1234, m2reg: 1'b0, mo: 32'h0});
        step(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, n);
        #2;
        check("alu_malu", malu, 32'h1234);
        check("alu_mrn", {27'd0, mrn}, 32'd5);
        check("alu_mwreg", {31'd0, mwreg}, 32'd1);
        check("alu_req", {31'd0, mem_req}, 32'd0);
        nop(n);
        check("alu_stalls", 32'(n), 32'd0);

        // load with 3 wait states
        lat       = 3;
        use_fixed = 1'b1;
        fixed_rd  = 32'hDEADBEEF;
        bus_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
        wb_q.push_back('{rn: 5'd7, alu: 32'h40, m2reg: 1'b1, mo: 32'hDEADBEEF});
        step(32'h40, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, n);
        nop(n);
        check("load3_stalls", 32'(n), 32'd3);
        use_fixed = 1'b0;

        // zero-wait store
        lat = 0;
        bus_q.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'hCAFEF00D});
        step(32'h80, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, n);
        #2;
        check("store_we", {31'd0, mem_we}, 32'd1);
        check("store_stall", {31'd0, mem_stall}, 32'd0);
        nop(n);
        check("store_stalls", 32'(n), 32'd0);
        #2;
        check("store_req_one_cycle", {31'd0, mem_req}, 32'd0);

        // load that never completes
        lat = -1;
        step(32'h200, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, n);
        #2;
        check("tmo_err_before", {31'd0, mem_err}, 32'd0);
        check("tmo_stall_first", {31'd0, mem_stall}, 32'd1);
        nop(n);
        check("tmo_stalls", 32'(n), 32'd15);
        #2;
        check("tmo_err_after", {31'd0, mem_err}, 32'd1);
        check("tmo_req_dropped", {31'd0, mem_req}, 32'd0);

        // back-to-back zero-wait loads
        lat = 0;
        bus_q.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0});
        bus_q.push_back('{we: 1'b0, addr: 32'h4, wdata: 32'h0});
        wb_q.push_back('{rn: 5'd10, alu: 32'h0, m2reg: 1'b1, mo: 32'hA5A50000});
        wb_q.push_back('{rn: 5'd11, alu: 32'h4, m2reg: 1'b1, mo: 32'hA5A50004});
        step(32'h0, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, n);
        step(32'h4, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, n);
        check("b2b_first_stalls", 32'(n), 32'd0);
        #2;
        check("b2b_req_second", {31'd0, mem_req}, 32'd1);
        check("b2b_addr_second", mem_addr, 32'h4);
        nop(n);
        check("b2b_second_stalls", 32'(n), 32'd0);

        // ack while idle must be ignored
        stray = 1'b1;
        @(posedge clock);
        #2;
        check("stray_mmo_held", mmo, 32'hA5A50004);
        check("stray_no_stall", {31'd0, mem_stall}, 32'd0);
        stray = 1'b0;
        @(posedge clock);
        #1;

        // clear sticky error before the alignment case
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("rst2_mem_err", {31'd0, mem_err}, 32'd0);
        @(posedge clock);
        #1;

`ifdef MEMACC_ALIGN_CHECK_EN
        step(32'h6, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, n);
        #2;
        check("misalign_no_req", {31'd0, mem_req}, 32'd0);
        check("misalign_err_before", {31'd0, mem_err}, 32'd0);
        nop(n);
        check("misalign_stalls", 32'(n), 32'd0);
        #2;
        check("misalign_err_after", {31'd0, mem_err}, 32'd1);
`else
        lat = 0;
        bus_q.push_back('{we: 1'b0, addr: 32'h6, wdata: 32'h0});
        wb_q.push_back('{rn: 5'd12, alu: 32'h6, m2reg: 1'b1, mo: 32'hA5A50006});
        step(32'h6, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, n);
        nop(n);
        check("unaligned_stalls", 32'(n), 32'd0);
        #2;
        check("unaligned_no_err", {31'd0, mem_err}, 32'd0);
`endif

        repeat (3) @(posedge clock);
        #1;
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
